// File: rtl/mem_io_responder_if.sv
// Request/response bus between the LC-3 datapath memory port and the responder.
// The initiator drives the request side; the responder returns registered data and status.
interface mem_io_responder_if;
   localparam int unsigned DATA_W = 16;

   logic              Req;
   logic              WE;
   logic [DATA_W-1:0] Addr;
   logic [DATA_W-1:0] WData;
   logic [DATA_W-1:0] RData;
   logic              Ready;
   logic              Busy;

   modport master (
      output Req, WE, Addr, WData,
      input  RData, Ready, Busy
   );

   modport slave (
      input  Req, WE, Addr, WData,
      output RData, Ready, Busy
   );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: word RAM plus one memory-mapped I/O word (switches in, hex display out),
// with configurable wait states and a four-phase Req/Ready handshake.
module mem_io_responder #(
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input  logic               Clk,
   input  logic               Reset_n,
   mem_io_responder_if.slave  bus,
   input  logic [15:0]        Switches,
   output logic [15:0]        Hex_Out
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 1 << ADDR_BITS;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   hex_q, hex_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;

   logic                is_io_c;
   logic                ram_we_c;
   logic [ADDR_BITS-1:0] ram_idx_c;

   // Storage is intentionally not reset; contents are undefined until written.
   logic [DATA_W-1:0]   ram_q [DEPTH];

   // The I/O word shadows its RAM alias, so decode on the full latched address.
   assign is_io_c   = (addr_q == IO_ADDR);
   assign ram_idx_c = addr_q[ADDR_BITS-1:0];

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         hex_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, access and output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      hex_d    = hex_q;
      ram_we_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.Req) begin
               addr_d  = bus.Addr;
               we_d    = bus.WE;
               wdata_d = bus.WData;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Access uses only the latched request; writes leave RData alone.
               if (we_q) begin
                  if (is_io_c) hex_d    = wdata_q;
                  else         ram_we_c = 1'b1;
               end else begin
                  rdata_d = is_io_c ? Switches : ram_q[ram_idx_c];
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (!bus.Req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == RESP);
      busy_d  = (state_d != IDLE);
   end

   // RAM write port; only reachable from WAIT, so an async reset cancels a pending write.
   always_ff @(posedge Clk) begin
      if (ram_we_c) ram_q[ram_idx_c] <= wdata_q;
   end

   assign bus.RData = rdata_q;
   assign bus.Ready = ready_q;
   assign bus.Busy  = busy_q;
   assign Hex_Out   = hex_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: transaction-level model of RAM, I/O word and handshake timing,
// compared against the DUT every cycle, plus directed literal checks.
module tb_mem_io_responder;
   localparam int unsigned WC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw;
   logic [15:0] hex;

   mem_io_responder_if bus_if();

   mem_io_responder #(
      .ADDR_BITS  (8),
      .WAIT_CYCLES(WC),
      .IO_ADDR    (16'hFFFF)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus_if.slave),
      .Switches(sw),
      .Hex_Out (hex)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   logic [15:0] m_mem [256];
   logic [15:0] m_rdata, m_hex;
   logic        m_ready, m_busy;
   bit          sw_churn;
   int          edge_cnt, ready_seen, first_ready;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare at the falling edge, then advance past the next rising edge.
   task automatic tick();
      @(negedge clk);
      chk("ready", 16'(bus_if.Ready), 16'(m_ready));
      chk("busy",  16'(bus_if.Busy),  16'(m_busy));
      chk("rdata", bus_if.RData, m_rdata);
      chk("hex",   hex, m_hex);
      if (bus_if.Ready === 1'b1) begin
         ready_seen++;
         if (first_ready < 0) first_ready = edge_cnt;
      end
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input int hold, input bit drop);
      bus_if.Req   = 1'b1;
      bus_if.WE    = we;
      bus_if.Addr  = addr;
      bus_if.WData = wd;
      tick();
      edge_cnt    = 0;
      ready_seen  = 0;
      first_ready = -1;
      m_busy      = 1'b1;
      m_ready     = 1'b0;
      bus_if.Addr  = 16'($urandom);
      bus_if.WData = 16'($urandom);
      bus_if.WE    = 1'($urandom);
      if (drop) bus_if.Req = 1'b0;
      for (int i = 0; i < int'(WC); i++) begin
         if (sw_churn) sw = 16'($urandom);
         tick();
      end
      tick();
      if (we) begin
         if (addr == 16'hFFFF) m_hex = wd;
         else                  m_mem[addr[7:0]] = wd;
      end else begin
         m_rdata = (addr == 16'hFFFF) ? sw : m_mem[addr[7:0]];
      end
      m_ready = 1'b1;
      if (!drop) begin
         for (int i = 0; i < hold; i++) begin
            if (sw_churn) sw = 16'($urandom);
            bus_if.Addr  = 16'($urandom);
            bus_if.WData = 16'($urandom);
            tick();
         end
      end
      bus_if.Req = 1'b0;
      tick();
      m_ready = 1'b0;
      m_busy  = 1'b0;
   endtask

   initial begin
      logic [15:0] saved;
      logic [15:0] a;
      bus_if.Req   = 1'b0;
      bus_if.WE    = 1'b0;
      bus_if.Addr  = '0;
      bus_if.WData = '0;
      sw       = 16'h0000;
      sw_churn = 1'b0;
      m_rdata  = '0;
      m_hex    = '0;
      m_ready  = 1'b0;
      m_busy   = 1'b0;
      edge_cnt = 0;
      ready_seen  = 0;
      first_ready = -1;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 16'(bus_if.Ready), 16'h0000);
      chk("rst_busy",  16'(bus_if.Busy),  16'h0000);
      chk("rst_rdata", bus_if.RData, 16'h0000);
      chk("rst_hex",   hex, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Fill every RAM word so later reads have defined expectations.
      for (int i = 0; i < 256; i++) begin
         a = {8'($urandom), 8'(i)};
         if (a == 16'hFFFF) a = 16'h00FF;
         txn(1'b1, a, 16'($urandom), 0, 1'b0);
      end

      txn(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
      chk("latency", 16'(first_ready), 16'd3);
      txn(1'b0, 16'h0010, 16'h0000, 5, 1'b0);
      chk("rd_beef", bus_if.RData, 16'hBEEF);
      chk("hold_ready_cycles", 16'(ready_seen), 16'd6);

      sw = 16'h1234;
      txn(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
      chk("rd_switch", bus_if.RData, 16'h1234);
      saved = m_mem[8'hFF];
      txn(1'b1, 16'hFFFF, 16'h00A5, 0, 1'b0);
      chk("hex_a5", hex, 16'h00A5);
      txn(1'b0, 16'h00FF, 16'h0000, 0, 1'b0);
      chk("ram_ff_kept", bus_if.RData, saved);

      txn(1'b1, 16'h0123, 16'h7777, 0, 1'b0);
      txn(1'b0, 16'h0023, 16'h0000, 0, 1'b0);
      chk("alias", bus_if.RData, 16'h7777);

      txn(1'b1, 16'h0042, 16'h1357, 0, 1'b1);
      chk("drop_ready_cycles", 16'(ready_seen), 16'd1);
      txn(1'b0, 16'h0042, 16'h0000, 0, 1'b0);
      chk("drop_write_landed", bus_if.RData, 16'h1357);

      // Reset during the wait phase of a write must cancel it.
      txn(1'b1, 16'h0005, 16'h0000, 0, 1'b0);
      bus_if.Req   = 1'b1;
      bus_if.WE    = 1'b1;
      bus_if.Addr  = 16'h0005;
      bus_if.WData = 16'hCAFE;
      tick();
      m_busy = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 16'(bus_if.Ready), 16'h0000);
      chk("mid_rst_busy",  16'(bus_if.Busy),  16'h0000);
      chk("mid_rst_hex",   hex, 16'h0000);
      m_ready = 1'b0;
      m_busy  = 1'b0;
      m_hex   = '0;
      m_rdata = '0;
      bus_if.Req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      txn(1'b0, 16'h0005, 16'h0000, 0, 1'b0);
      chk("rst_write_cancelled", bus_if.RData, 16'h0000);

      // Randomized traffic with switch churn, holds, protocol violations and idle gaps.
      sw_churn = 1'b1;
      for (int n = 0; n < 200; n++) begin
         a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
         txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the LC-3 datapath's memory port. It accepts read and write requests carrying an address (from MAR) and write data (from MDR), and returns read data for the datapath's MDR input. It holds an on-chip word RAM plus one memory-mapped I/O word: switches on read, hex display register on write. Access latency is a configurable number of wait states, and each transfer completes with a four-phase Req/Ready handshake.

## Interface
- ADDR_BITS, 8 — RAM depth is 2^ADDR_BITS 16-bit words.
- WAIT_CYCLES, 2 — extra wait cycles inserted before each access; legal range 0–15.
- IO_ADDR, 16'hFFFF — full 16-bit address of the I/O word.

Ports:
- Clk  in  1  sole clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  request level from initiator; four-phase handshake.
- WE  in  1  1 = write, 0 = read; sampled with Req.
- Addr  in  16  word address (MAR).
- WData  in  16  write data (MDR).
- Switches  in  16  board switch inputs, returned on reads of IO_ADDR.
- RData  out  16  read data (to datapath MDR_In).
- Ready  out  1  transfer complete; RData valid while high.
- Busy  out  1  high whenever state ≠ IDLE.
- Hex_Out  out  16  display register, written via IO_ADDR.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: when Req=1 at a rising edge, latch Addr, WE and WData into internal registers, load the wait counter with WAIT_CYCLES, and go to WAIT.
- WAIT, counter ≠ 0: decrement the counter and stay in WAIT.
- WAIT, counter = 0: perform the access on the latched values, then go to RESP.
  - Write to IO_ADDR: Hex_Out ← WData.
  - Write elsewhere: RAM[Addr[ADDR_BITS-1:0]] ← WData.
  - Read of IO_ADDR: RData ← Switches, sampled at this edge.
  - Read elsewhere: RData ← RAM[Addr[ADDR_BITS-1:0]].
  - Writes leave RData unchanged.
- RESP: Ready=1. Stay while Req=1. When Req=0 at an edge, go to IDLE with Ready=0.
- Address decode:
  - Any address other than IO_ADDR aliases into the RAM using its low ADDR_BITS bits (modulo wrap).
  - IO_ADDR never touches the RAM, even though its low bits alias a RAM word.
- Addr, WE and WData changes after acceptance are ignored; the latched copies are used.
- Req dropped during WAIT (protocol violation): the access still completes. RESP is entered with Req=0, so Ready is high for exactly one cycle, then IDLE.
- Back-to-back transfers: a new request is accepted only from IDLE. This requires at least one cycle with Req=0 between transfers.

## Timing
- Reset_n=0 asynchronously forces:
  - state = IDLE, counter = 0;
  - RData = 16'h0000, Ready = 0, Busy = 0, Hex_Out = 16'h0000.
- RAM contents are not reset and are undefined until written.
- Reset mid-transaction aborts it.
  - A write whose access edge has not yet occurred has no effect.
  - After reset is released, the responder waits in IDLE for Req.
- Latency: acceptance edge E0 → access edge E0+WAIT_CYCLES+1 → Ready high in the following cycle.
  - WAIT_CYCLES=0: Ready goes high after the 2nd edge counted from and including E0.
- Busy rises the cycle after acceptance and falls together with Ready.
- Ready and RData are registered outputs with no combinational path from the inputs.
- Minimum full transfer with Req dropped the cycle after Ready: WAIT_CYCLES+3 cycles from Req rise to IDLE.

## Test plan
- RAM write/read, WAIT_CYCLES=2:
  - Write 16'hBEEF to 16'h0010; Ready rises exactly 3 edges after acceptance.
  - Read 16'h0010 → RData=16'hBEEF with Ready=1.
- I/O path, with Switches=16'h1234:
  - Read 16'hFFFF → RData=16'h1234.
  - Write 16'hFFFF with 16'h00A5 → Hex_Out=16'h00A5.
  - RAM[8'hFF] is unchanged.
- Aliasing, ADDR_BITS=8: write 16'h7777 to 16'h0123, then read 16'h0023 → 16'h7777.
- Handshake:
  - Hold Req high 5 cycles after Ready → Ready and Busy stay 1, and no second access occurs.
  - Drop Req → IDLE on the next edge, and a new request is accepted after that.
- Protocol violation: drop Req in WAIT → write still lands, and Ready is high for exactly one cycle.
- Reset mid-write:
  - Assert Reset_n=0 asynchronously during WAIT of a write of 16'hCAFE to 16'h0005 → Ready=0, Busy=0, Hex_Out=0 immediately.
  - After release, a read of 16'h0005 does not return 16'hCAFE when RAM[5] was previously written with 16'h0000.
